sp_command_dispatcher: RTL and testbench
========================================

Name: sp_command_dispatcher

Overview:
Sits between the service-protocol unpacker and the command handlers (MIL transmitter, status responder, etc.). Stages each packet's data words in a circular buffer and commits the packet only after the unpacker reports a good CRC, address match and a known command. Rolls back packets that fail. Queues committed commands and hands them out one at a time: the handler accepts each command and then pulls its data words.

Parameters:
DEPTH, 64, staging buffer depth in 16-bit words; power of two, at least 4.
CMDQ, 4, command queue depth in entries; power of two, at least 2.
CODE_W, 4, command code width; code 0 means unknown.
BCAST_ADDR, 8'hFF, broadcast module address, always accepted.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_data  in  16  unpacked data word
in_request  in  1  one-cycle strobe; in_data is valid
pkt_start  in  1  one-cycle pulse; new packet begins
pkt_end  in  1  one-cycle pulse; CRC good
pkt_err  in  1  one-cycle pulse; CRC bad
pkt_addr  in  8  packet module address, valid with pkt_end
pkt_cmd  in  CODE_W  packet command code, valid with pkt_end
module_addr  in  8  this module's own address
cmd_valid  out  1  command offered
cmd_code  out  CODE_W  offered command code
cmd_size  out  8  offered command's word count
cmd_ready  in  1  handler accepts the offered command
rd_request  in  1  handler pulls the next word
rd_data  out  16  pulled word
rd_valid  out  1  rd_data is valid
busy  out  1  queue non-empty or dispatch in progress
drop_cnt  out  8  count of discarded packets, saturating

Behaviour:
- Reset: all pointers 0, command queue empty, dispatch FSM in IDLE. cmd_valid=0, cmd_code=0, cmd_size=0, rd_data=0, rd_valid=0, busy=0, drop_cnt=0. Reset mid-operation discards all staged and queued data.
- Pointers wr_ptr, base_ptr and rd_ptr are each log2(DEPTH)+1 bits wide. used = wr_ptr - rd_ptr (modulo). full = (used == DEPTH). Addressing wraps naturally.
- Receive side:
  - pkt_start: base_ptr<=wr_ptr, word_cnt<=0, ovf<=0, in_pkt<=1.
  - If pkt_start arrives while in_pkt=1, the old packet is aborted first: wr_ptr<=base_ptr and drop_cnt increments. The new packet's base is the rewound pointer.
  - in_request with in_pkt=1 and not full: write mem[wr_ptr], wr_ptr++, word_cnt++.
  - in_request while full: ovf<=1 and the word is discarded.
  - in_request with in_pkt=0: ignored.
  - word_cnt saturates at 255; reaching 256 sets ovf.
- pkt_end, commit condition: in_pkt & !ovf & pkt_cmd!=0 & queue not full & (pkt_addr==module_addr or pkt_addr==BCAST_ADDR).
  - Commit: push {pkt_cmd, word_cnt} and base_ptr stays as committed.
  - Address mismatch (all else OK): rewind wr_ptr<=base_ptr, drop_cnt unchanged.
  - Any other failure: rewind and drop_cnt+1.
  - in_pkt<=0 in every case.
- pkt_err: rewind, drop_cnt+1 if in_pkt, in_pkt<=0.
- pkt_end/pkt_err and in_request in the same cycle: the word is written first, then the end is evaluated, so the word is included in the commit.
- pkt_start and pkt_end in the same cycle: end applies to the old packet, then start applies.
- drop_cnt saturates at 255.
- Dispatch FSM:
  - IDLE: if queue non-empty, load head into cmd_code/cmd_size, set cmd_valid=1, go to OFFER.
  - OFFER: hold outputs until cmd_ready=1. Then cmd_valid<=0, remaining<=cmd_size. Go to STREAM if cmd_size!=0, else pop and go to IDLE.
  - STREAM: on rd_request, rd_data<=mem[rd_ptr], rd_valid<=1 the next cycle (latency 1), rd_ptr++, remaining--. At remaining reaching 0, pop and go to IDLE.
  - rd_request outside STREAM is ignored and rd_valid stays 0. rd_valid is a one-cycle pulse per word.
- Only committed words are ever read, because the producer never overtakes rd_ptr. A read and a write in the same cycle are legal; the read frees space visible on the next cycle.
- Queue push and pop in the same cycle are legal; the queue count is unchanged.
- busy = queue non-empty | state!=IDLE.

Test Plan:
- module_addr=5, packet addr 5, cmd 3, words A1,A2,A3, pkt_end -> cmd_valid with code 3, size 3. After cmd_ready and 3 rd_requests, rd_data = A1,A2,A3 each 1 cycle after its request. busy drops to 0.
- Packet of 4 words then pkt_err -> no cmd_valid, drop_cnt=1. Next good 2-word packet B1,B2 reads back B1,B2 (rewind verified).
- Addr 7 (mismatch) -> discarded, drop_cnt unchanged. Addr 8'hFF -> accepted. cmd 0 -> drop_cnt+1.
- DEPTH=64 with a handler that never accepts: 70-word packet -> ovf, dropped, drop_cnt+1, buffer empty. A following 64-word packet commits, full asserted with no corruption.
- Five zero-size good packets with cmd_ready held low, CMDQ=4 -> four queued, fifth dropped (drop_cnt+1). Releasing cmd_ready yields 4 commands of size 0, with no rd_valid.
- Reset asserted mid-STREAM with 2 of 5 words read -> next cycle all outputs 0, busy=0, a new packet dispatches correctly from address 0.

Source files
------------

// File: rtl/sp_command_dispatcher.sv
// Service-protocol command dispatcher: stages packet words in a circular buffer,
// commits or rolls back each packet, and hands queued commands to a handler.
module sp_command_dispatcher #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned CMDQ       = 4,
    parameter int unsigned CODE_W     = 4,
    parameter logic [7:0]  BCAST_ADDR = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       in_data,
    input  logic              in_request,
    input  logic              pkt_start,
    input  logic              pkt_end,
    input  logic              pkt_err,
    input  logic [7:0]        pkt_addr,
    input  logic [CODE_W-1:0] pkt_cmd,
    input  logic [7:0]        module_addr,
    output logic              cmd_valid,
    output logic [CODE_W-1:0] cmd_code,
    output logic [7:0]        cmd_size,
    input  logic              cmd_ready,
    input  logic              rd_request,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned QW  = $clog2(CMDQ);
    localparam int unsigned QCW = QW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OFFER  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    logic [15:0]       mem_q [DEPTH];
    logic [CODE_W-1:0] q_code_q [CMDQ];
    logic [7:0]        q_size_q [CMDQ];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, base_ptr_q, base_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]        word_cnt_q, word_cnt_d, wc_w;
    logic              ovf_q, ovf_d, in_pkt_q, in_pkt_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [QW-1:0]     q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [QCW-1:0]    q_count_q, q_count_d;
    logic [1:0]        state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [CODE_W-1:0] cmd_code_q, cmd_code_d;
    logic [7:0]        cmd_size_q, cmd_size_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;

    logic [PW-1:0]     used;
    logic              full, q_full, addr_ok, cmd_ok, mem_we, push, pop, drop_inc;

    assign used    = wr_ptr_q - rd_ptr_q;
    assign full    = (used == PW'(DEPTH));
    assign q_full  = (q_count_q == QCW'(CMDQ));
    assign addr_ok = (pkt_addr == module_addr) || (pkt_addr == BCAST_ADDR);
    assign cmd_ok  = (pkt_cmd != '0);

    // Receive side, in order: word write, then packet end/error, then packet start.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        base_ptr_d = base_ptr_q;
        word_cnt_d = word_cnt_q;
        ovf_d      = ovf_q;
        in_pkt_d   = in_pkt_q;
        mem_we     = 1'b0;
        push       = 1'b0;
        drop_inc   = 1'b0;
        if (in_request && in_pkt_q) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                if (word_cnt_q == 8'hFF) ovf_d = 1'b1;
                else                     word_cnt_d = word_cnt_q + 8'd1;
            end
        end
        wc_w = word_cnt_d;
        if (in_pkt_q && (pkt_end || pkt_err)) begin
            in_pkt_d = 1'b0;
            if (!pkt_err && !ovf_d && cmd_ok && !q_full && addr_ok) begin
                push = 1'b1;
            end else begin
                wr_ptr_d = base_ptr_q;
                // A pure address mismatch is someone else's packet, not a drop.
                drop_inc = pkt_err || ovf_d || !cmd_ok || q_full;
            end
        end
        if (pkt_start) begin
            if (in_pkt_d) begin
                wr_ptr_d = base_ptr_q;
                drop_inc = 1'b1;
            end
            base_ptr_d = wr_ptr_d;
            word_cnt_d = 8'd0;
            ovf_d      = 1'b0;
            in_pkt_d   = 1'b1;
        end
        drop_cnt_d = (drop_inc && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end

    // Dispatch FSM: offer head command, then stream its words on request.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        cmd_size_d  = cmd_size_q;
        remaining_d = remaining_q;
        rd_ptr_d    = rd_ptr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (q_count_q != '0) begin
                    cmd_code_d  = q_code_q[q_head_q];
                    cmd_size_d  = q_size_q[q_head_q];
                    cmd_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    remaining_d = cmd_size_q;
                    if (cmd_size_q != 8'd0) begin
                        state_d = ST_STREAM;
                    end else begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STREAM: begin
                if (rd_request) begin
                    rd_data_d   = mem_q[rd_ptr_q[AW-1:0]];
                    rd_valid_d  = 1'b1;
                    rd_ptr_d    = rd_ptr_q + PW'(1);
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        q_head_d  = pop  ? q_head_q + QW'(1) : q_head_q;
        q_tail_d  = push ? q_tail_q + QW'(1) : q_tail_q;
        q_count_d = q_count_q + QCW'(push) - QCW'(pop);
        busy_d    = (q_count_d != '0) || (state_d != ST_IDLE);
    end

    // Storage arrays carry no reset; pointers and counts define their validity.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        if (push) begin
            q_code_q[q_tail_q] <= pkt_cmd;
            q_size_q[q_tail_q] <= wc_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            base_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            word_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            in_pkt_q    <= 1'b0;
            drop_cnt_q  <= '0;
            q_head_q    <= '0;
            q_tail_q    <= '0;
            q_count_q   <= '0;
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            cmd_size_q  <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            base_ptr_q  <= base_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            word_cnt_q  <= word_cnt_d;
            ovf_q       <= ovf_d;
            in_pkt_q    <= in_pkt_d;
            drop_cnt_q  <= drop_cnt_d;
            q_head_q    <= q_head_d;
            q_tail_q    <= q_tail_d;
            q_count_q   <= q_count_d;
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_size_q  <= cmd_size_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_size  = cmd_size_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sp_command_dispatcher.sv
// Directed bench for sp_command_dispatcher: packet vector table plus corner-case sequences.
module tb_sp_command_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_request = 1'b0;
    logic        pkt_start = 1'b0;
    logic        pkt_end = 1'b0;
    logic        pkt_err = 1'b0;
    logic [7:0]  pkt_addr = '0;
    logic [3:0]  pkt_cmd = '0;
    logic [7:0]  module_addr = 8'd5;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [7:0]  cmd_size;
    logic        cmd_ready = 1'b0;
    logic        rd_request = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic [7:0]  drop_cnt;

    int          n_pass = 0;
    int          n_total = 0;
    logic [7:0]  exp_drop = '0;

    sp_command_dispatcher #(.DEPTH(64), .CMDQ(4), .CODE_W(4), .BCAST_ADDR(8'hFF)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_request(in_request),
        .pkt_start(pkt_start), .pkt_end(pkt_end), .pkt_err(pkt_err),
        .pkt_addr(pkt_addr), .pkt_cmd(pkt_cmd), .module_addr(module_addr),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_size(cmd_size),
        .cmd_ready(cmd_ready), .rd_request(rd_request), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  cmd;
        int          n;
        logic [15:0] base;
        bit          err;
        bit          merge;
        bit          commit;
        bit          drop;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send_pkt(input logic [7:0] addr, input logic [3:0] cmd, input int n,
                            input logic [15:0] base, input bit err, input bit merge);
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_request = 1'b1;
            in_data    = base + 16'(i);
            if (merge && i == n - 1) begin
                pkt_end  = !err;
                pkt_err  = err;
                pkt_addr = addr;
                pkt_cmd  = cmd;
            end
            tick();
            in_request = 1'b0;
            pkt_end    = 1'b0;
            pkt_err    = 1'b0;
        end
        if (!(merge && n > 0)) begin
            pkt_end  = !err;
            pkt_err  = err;
            pkt_addr = addr;
            pkt_cmd  = cmd;
            tick();
            pkt_end = 1'b0;
            pkt_err = 1'b0;
        end
    endtask

    task automatic wait_cmd();
        int n = 0;
        while (!cmd_valid && n < 20) begin
            tick();
            n++;
        end
        check("cmd_valid_seen", 32'(cmd_valid), 32'd1);
    endtask

    // Accept the offered command and pull all of its words back-to-back.
    task automatic take_cmd(input logic [3:0] code, input logic [7:0] size, input logic [15:0] base);
        wait_cmd();
        check("cmd_code", 32'(cmd_code), 32'(code));
        check("cmd_size", 32'(cmd_size), 32'(size));
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("cmd_valid_drop", 32'(cmd_valid), 32'd0);
        rd_request = (size != 8'd0);
        for (int i = 0; i < int'(size); i++) begin
            tick();
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", 32'(rd_data), 32'(base + 16'(i)));
        end
        rd_request = 1'b0;
        tick();
        check("rd_valid_idle", 32'(rd_valid), 32'd0);
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{8'd5,   4'd3, 3, 16'hA001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'd5,   4'd2, 4, 16'h9001, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'd5,   4'd4, 2, 16'hB001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'd7,   4'd3, 2, 16'h7001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hFF,  4'd6, 3, 16'hF001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'd5,   4'd0, 2, 16'h0A01, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'd5,   4'd9, 1, 16'h5501, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{8'd7,   4'd0, 1, 16'h7701, 1'b0, 1'b0, 1'b0, 1'b1};

        tick();
        tick();
        rst = 1'b0;
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code",  32'(cmd_code),  32'd0);
        check("rst_cmd_size",  32'(cmd_size),  32'd0);
        check("rst_rd_data",   32'(rd_data),   32'd0);
        check("rst_rd_valid",  32'(rd_valid),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_drop_cnt",  32'(drop_cnt),  32'd0);

        foreach (vecs[k]) begin
            send_pkt(vecs[k].addr, vecs[k].cmd, vecs[k].n, vecs[k].base, vecs[k].err, vecs[k].merge);
            if (vecs[k].drop) exp_drop++;
            if (vecs[k].commit) begin
                take_cmd(vecs[k].cmd, 8'(vecs[k].n), vecs[k].base);
            end else begin
                tick();
                tick();
                check("no_cmd_valid", 32'(cmd_valid), 32'd0);
            end
            check("vec_busy_end", 32'(busy), 32'd0);
            check("vec_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        end

        // A new start mid-packet aborts and rewinds the old one.
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_request = 1'b1;
            in_data = 16'hD000 + 16'(i);
            tick();
        end
        in_request = 1'b0;
        send_pkt(8'd5, 4'd7, 2, 16'hE000, 1'b0, 1'b0);
        exp_drop++;
        check("abort_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        take_cmd(4'd7, 8'd2, 16'hE000);

        // Overflow: 70 words into a 64-deep buffer, then a full 64-word packet.
        send_pkt(8'd5, 4'd3, 70, 16'h1000, 1'b0, 1'b0);
        exp_drop++;
        tick();
        check("ovf_no_cmd", 32'(cmd_valid), 32'd0);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        send_pkt(8'd5, 4'd5, 64, 16'hC000, 1'b0, 1'b0);
        wait_cmd();
        send_pkt(8'd5, 4'd6, 1, 16'h2000, 1'b0, 1'b0);
        exp_drop++;
        check("full_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        take_cmd(4'd5, 8'd64, 16'hC000);
        check("full_busy_end", 32'(busy), 32'd0);

        // Queue full: five zero-size packets with the handler stalled.
        for (int i = 1; i <= 5; i++) begin
            send_pkt(8'd5, 4'(i), 0, 16'h0000, 1'b0, 1'b0);
        end
        exp_drop++;
        check("qfull_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        check("qfull_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            take_cmd(4'(i), 8'd0, 16'h0000);
        end
        tick();
        check("qfull_no_fifth", 32'(cmd_valid), 32'd0);
        check("qfull_busy_end", 32'(busy), 32'd0);

        // Reset in the middle of streaming a 5-word command.
        send_pkt(8'd5, 4'd8, 5, 16'h3000, 1'b0, 1'b0);
        wait_cmd();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        rd_request = 1'b1;
        tick();
        tick();
        check("pre_rst_rd_data", 32'(rd_data), 32'h3001);
        rd_request = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("mid_rst_cmd_code",  32'(cmd_code),  32'd0);
        check("mid_rst_cmd_size",  32'(cmd_size),  32'd0);
        check("mid_rst_rd_data",   32'(rd_data),   32'd0);
        check("mid_rst_rd_valid",  32'(rd_valid),  32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_drop_cnt",  32'(drop_cnt),  32'd0);
        send_pkt(8'd5, 4'd2, 2, 16'h4000, 1'b0, 1'b0);
        take_cmd(4'd2, 8'd2, 16'h4000);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
